// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: flag register, 2-bit predictor table, branch resolve and redirect (optional BRANCH_STATS_EN counters)
module branch_resolve_unit #(
    parameter int          AW       = 16,
    parameter int          DEPTH    = 16,
    parameter int          IDX_LSB  = 0,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] fetch_pc,
    output logic          pred_taken,
    input  logic          flag_we,
    input  logic          n_in,
    input  logic          z_in,
    input  logic          v_in,
    output logic [2:0]    flags,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_pc,
    input  logic [2:0]    ex_op,
    input  logic          ex_pred_taken,
    input  logic [AW-1:0] ex_target,
    input  logic [AW-1:0] ex_fallthru,
    output logic          take_branch,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]   br_count,
    output logic [31:0]   mis_count
`endif
);
    localparam int IW = $clog2(DEPTH);
    logic [1:0]    predTable [DEPTH];
    logic [2:0]    flagReg;
    logic [2:0]    effFlags;
    logic [IW-1:0] fetchIdx;
    logic [IW-1:0] exIdx;
    logic [1:0]    exCnt;
    logic          fN, fZ, fV;
    logic          cond;
    logic          mis;
    assign fetchIdx   = fetch_pc[IDX_LSB +: IW];
    assign exIdx      = ex_pc[IDX_LSB +: IW];
    assign exCnt      = predTable[exIdx];
    assign pred_taken = predTable[fetchIdx][1];
    assign flags      = flagReg;
    assign {fN, fZ, fV} = effFlags;
    // resolve the EX branch on bypassed flags and detect a mispredict
    always_comb begin
        effFlags = (flag_we && ex_valid) ? {n_in, z_in, v_in} : flagReg;
        cond = 1'b0;
        case (ex_op)
            3'b000:  cond = !fZ;
            3'b001:  cond = fZ;
            3'b010:  cond = !fZ && !fN;
            3'b011:  cond = fN;
            3'b100:  cond = !fN;
            3'b101:  cond = fN || fZ;
            3'b110:  cond = fV;
            default: cond = 1'b1;
        endcase
        take_branch = ex_valid && cond;
        mis = ex_valid && (take_branch != ex_pred_taken);
    end
    // architectural flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flagReg <= 3'b000;
        else if (flag_we) flagReg <= {n_in, z_in, v_in};
    end
    // saturating counter training at the EX branch's index; reads see the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) predTable[i] <= CNT_INIT;
        end else if (ex_valid) begin
            predTable[exIdx] <= take_branch ? ((exCnt == 2'b11) ? exCnt : exCnt + 2'd1)
                                            : ((exCnt == 2'b00) ? exCnt : exCnt - 2'd1);
        end
    end
    // one-cycle redirect pulse carrying the corrected PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mis;
            if (mis) redirect_pc <= take_branch ? ex_target : ex_fallthru;
        end
    end
`ifdef BRANCH_STATS_EN
    // resolved-branch and mispredict event counters, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (ex_valid) br_count <= br_count + 32'd1;
            if (mis) mis_count <= mis_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed table and sequences for branch_resolve_unit (BRANCH_STATS_EN aware)
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fetchPc = '0;
    logic        predTaken;
    logic        flagWe = 1'b0;
    logic        nIn = 1'b0, zIn = 1'b0, vIn = 1'b0;
    logic [2:0]  flags;
    logic        exValid = 1'b0;
    logic [15:0] exPc = '0;
    logic [2:0]  exOp = '0;
    logic        exPredTaken = 1'b0;
    logic [15:0] exTarget = '0;
    logic [15:0] exFallthru = '0;
    logic        takeBranch;
    logic        redirectValid;
    logic [15:0] redirectPc;
`ifdef BRANCH_STATS_EN
    logic [31:0] brCount, misCount;
`endif
    int errors = 0;
    int checks = 0;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetchPc), .pred_taken(predTaken),
        .flag_we(flagWe), .n_in(nIn), .z_in(zIn), .v_in(vIn), .flags(flags),
        .ex_valid(exValid), .ex_pc(exPc), .ex_op(exOp), .ex_pred_taken(exPredTaken),
        .ex_target(exTarget), .ex_fallthru(exFallthru), .take_branch(takeBranch),
        .redirect_valid(redirectValid), .redirect_pc(redirectPc)
`ifdef BRANCH_STATS_EN
        , .br_count(brCount), .mis_count(misCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [2:0] nzv;
        logic       valid;
        logic [2:0] op;
        logic       take;
        logic [2:0] fl;
    } vec_t;
    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic v, input logic [2:0] op, input logic p, input logic [15:0] pc,
                      input logic [15:0] tgt, input logic [15:0] ft);
        exValid = v; exOp = op; exPredTaken = p; exPc = pc; exTarget = tgt; exFallthru = ft;
    endtask

    task automatic doReset;
        flagWe = 0; {nIn, zIn, vIn} = 3'b000; br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        rst_n = 0;
        tick; tick;
        rst_n = 1;
        #1;
    endtask

    initial begin
        logic [15:0] expPc;
        vecs[0]  = '{1'b1, 3'b010, 1'b1, 3'd1, 1'b1, 3'b010};
        vecs[1]  = '{1'b1, 3'b000, 1'b1, 3'd1, 1'b0, 3'b000};
        vecs[2]  = '{1'b1, 3'b100, 1'b1, 3'd3, 1'b1, 3'b100};
        vecs[3]  = '{1'b0, 3'b000, 1'b1, 3'd0, 1'b1, 3'b100};
        vecs[4]  = '{1'b0, 3'b000, 1'b1, 3'd2, 1'b0, 3'b100};
        vecs[5]  = '{1'b1, 3'b000, 1'b1, 3'd2, 1'b1, 3'b000};
        vecs[6]  = '{1'b1, 3'b010, 1'b1, 3'd4, 1'b1, 3'b010};
        vecs[7]  = '{1'b0, 3'b000, 1'b1, 3'd5, 1'b1, 3'b010};
        vecs[8]  = '{1'b0, 3'b000, 1'b1, 3'd0, 1'b0, 3'b010};
        vecs[9]  = '{1'b1, 3'b001, 1'b1, 3'd6, 1'b1, 3'b001};
        vecs[10] = '{1'b1, 3'b110, 1'b1, 3'd6, 1'b0, 3'b110};
        vecs[11] = '{1'b0, 3'b000, 1'b1, 3'd5, 1'b1, 3'b110};
        vecs[12] = '{1'b0, 3'b000, 1'b1, 3'd4, 1'b0, 3'b110};
        vecs[13] = '{1'b0, 3'b000, 1'b0, 3'd7, 1'b0, 3'b110};
        vecs[14] = '{1'b1, 3'b000, 1'b0, 3'd7, 1'b0, 3'b000};
        vecs[15] = '{1'b0, 3'b000, 1'b1, 3'd7, 1'b1, 3'b000};
        vecs[16] = '{1'b1, 3'b100, 1'b0, 3'd1, 1'b0, 3'b100};
        vecs[17] = '{1'b0, 3'b000, 1'b1, 3'd3, 1'b1, 3'b100};

        // reset state
        doReset;
        fetchPc = 16'h0004; #1;
        chk("reset_pred", predTaken, 0);
        chk("reset_flags", flags, 0);
        chk("reset_rv", redirectValid, 0);
        chk("reset_rpc", redirectPc, 0);

        // condition table: prediction 0 so every taken branch redirects to its target
        expPc = 16'h0;
        for (int i = 0; i < 18; i++) begin
            flagWe = vecs[i].we; {nIn, zIn, vIn} = vecs[i].nzv;
            br(vecs[i].valid, vecs[i].op, 0, 16'h0020, 16'h0100 + 16'(i), 16'h0200);
            #1;
            chk($sformatf("vec%0d_take", i), takeBranch, vecs[i].take);
            tick;
            if (vecs[i].take) expPc = 16'h0100 + 16'(i);
            chk($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
            chk($sformatf("vec%0d_rv", i), redirectValid, vecs[i].take);
            chk($sformatf("vec%0d_rpc", i), redirectPc, expPc);
        end

        // BEQ after Z written: single redirect pulse to target
        doReset;
        flagWe = 1; zIn = 1; tick;
        flagWe = 0; zIn = 0;
        br(1, 3'd1, 0, 16'h0030, 16'h0040, 16'h0034); #1;
        chk("beq_take", takeBranch, 1);
        tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        chk("beq_rv", redirectValid, 1);
        chk("beq_rpc", redirectPc, 16'h0040);
        tick;
        chk("beq_rv_drop", redirectValid, 0);
        chk("beq_rpc_hold", redirectPc, 16'h0040);

        // predictor training, aliasing, saturation
        doReset;
        fetchPc = 16'h0008;
        br(1, 3'd7, 1, 16'h0008, 16'h0080, 16'h000a); #1;
        chk("collide_pre", predTaken, 0);
        tick;
        chk("train1", predTaken, 1);
        tick;
        chk("train2", predTaken, 1);
        tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        chk("train3", predTaken, 1);
        fetchPc = 16'h0018; #1;
        chk("alias", predTaken, 1);
        fetchPc = 16'h0009; #1;
        chk("other_entry", predTaken, 0);
        fetchPc = 16'h0008;
        br(1, 3'd6, 0, 16'h0008, 16'h0080, 16'h000a); tick;
        chk("nt1", predTaken, 1);
        tick;
        chk("nt2", predTaken, 0);
        tick; tick;
        br(1, 3'd7, 1, 16'h0008, 16'h0080, 16'h000a); tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        chk("sat_low", predTaken, 0);

        // BUNCOND predicted taken, then BOVFL mispredicted taken
        br(1, 3'd7, 1, 16'h0010, 16'h0070, 16'h0012); #1;
        chk("uncond_take", takeBranch, 1);
        tick;
        chk("uncond_rv", redirectValid, 0);
        br(1, 3'd6, 1, 16'h0010, 16'h0070, 16'h0012); #1;
        chk("ovfl_take", takeBranch, 0);
        tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        chk("ovfl_rv", redirectValid, 1);
        chk("ovfl_rpc", redirectPc, 16'h0012);

        // back-to-back mispredicts
        doReset;
        br(1, 3'd7, 0, 16'h0001, 16'h0050, 16'h0002); tick;
        chk("b2b_rv1", redirectValid, 1);
        chk("b2b_rpc1", redirectPc, 16'h0050);
        br(1, 3'd6, 1, 16'h0002, 16'h0055, 16'h0060); tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        chk("b2b_rv2", redirectValid, 1);
        chk("b2b_rpc2", redirectPc, 16'h0060);
        tick;
        chk("b2b_rv3", redirectValid, 0);
        chk("b2b_hold", redirectPc, 16'h0060);

        // reset while redirecting: table and flags clear
        flagWe = 1; {nIn, zIn, vIn} = 3'b111;
        br(1, 3'd7, 1, 16'h0003, 16'h0090, 16'h0004); tick;
        flagWe = 0;
        br(1, 3'd7, 0, 16'h0003, 16'h0090, 16'h0004); tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0);
        fetchPc = 16'h0003; #1;
        chk("pre_rst_pred", predTaken, 1);
        chk("pre_rst_rv", redirectValid, 1);
        rst_n = 0; #1;
        chk("rst_rv_async", redirectValid, 0);
        chk("rst_flags", flags, 0);
        tick;
        rst_n = 1; #1;
        for (int i = 0; i < 16; i++) begin
            fetchPc = 16'(i); #1;
            chk($sformatf("post_rst_pred%0d", i), predTaken, 0);
        end

`ifdef BRANCH_STATS_EN
        doReset;
        br(1, 3'd7, 1, 16'h0, 16'h0, 16'h0); tick;
        br(1, 3'd7, 0, 16'h0, 16'h0, 16'h0); tick;
        br(1, 3'd6, 0, 16'h0, 16'h0, 16'h0); tick;
        br(1, 3'd6, 1, 16'h0, 16'h0, 16'h0); tick;
        br(1, 3'd1, 0, 16'h0, 16'h0, 16'h0); tick;
        br(0, 3'd0, 0, 16'h0, 16'h0, 16'h0); tick;
        chk("br_count", brCount, 5);
        chk("mis_count", misCount, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational branch-condition decoder.
- Holds the architectural N/Z/V flag register and a DEPTH-entry table of 2-bit saturating branch predictors.
- Gives a taken/not-taken prediction to fetch, resolves branches in execute, trains the table, and issues a registered redirect on a mispredict.
- Sits between the ALU flag outputs, the EX-stage branch op decode and the PC-select mux.

Parameters:
- AW, 16, PC/target address width in bits.
- DEPTH, 16, number of predictor entries; must be a power of 2, at least 2.
- IDX_LSB, 0, lowest PC bit used for the table index. Index = pc[IDX_LSB+log2(DEPTH)-1 : IDX_LSB].
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_pc  input  AW  PC of instruction being fetched
- pred_taken  output  1  combinational prediction for fetch_pc: counter MSB
- flag_we  input  1  ALU writes flags this cycle
- n_in, z_in, v_in  input  1 each  ALU result flags
- flags  output  3  registered {N,Z,V}
- ex_valid  input  1  EX stage holds a branch
- ex_pc  input  AW  PC of EX branch
- ex_op  input  3  branch op: 000 BNEQ, 001 BEQ, 010 BGT, 011 BLT, 100 BGTE, 101 BLTE, 110 BOVFL, 111 BUNCOND
- ex_pred_taken  input  1  prediction that travelled with the branch
- ex_target  input  AW  taken target
- ex_fallthru  input  AW  not-taken PC
- take_branch  output  1  combinational resolved outcome; 0 when ex_valid=0
- redirect_valid  output  1  registered mispredict pulse
- redirect_pc  output  AW  registered correct PC

Behaviour:
- Reset (async, rst_n=0):
  - flags=3'b000, redirect_valid=0, redirect_pc=0.
  - Every counter = CNT_INIT.
  - pred_taken reflects CNT_INIT MSB (0 by default).
- Conditions, evaluated on the effective flags:
  - BNEQ: !Z. BEQ: Z. BGT: !Z & !N. BLT: N. BGTE: !N. BLTE: N|Z. BOVFL: V. BUNCOND: 1.
- Flag bypass: when flag_we=1 and ex_valid=1 in the same cycle, the effective flags are {n_in,z_in,v_in}. Otherwise the effective flags are the flags register.
- Flag register: loads {n_in,z_in,v_in} on the clk edge when flag_we=1; otherwise holds.
- Counter training, on the clk edge when ex_valid=1, at index(ex_pc):
  - take_branch=1: counter increments, saturating at 2'b11.
  - take_branch=0: counter decrements, saturating at 2'b00.
  - BUNCOND trains toward taken.
- Read/write collision: if fetch_pc and ex_pc map to the same index in the same cycle, pred_taken returns the pre-update value. There is no write-to-read bypass.
- Mispredict: mis = ex_valid & (take_branch != ex_pred_taken).
  - On the next clk edge: redirect_valid <= mis; redirect_pc <= take_branch ? ex_target : ex_fallthru, loaded only when mis=1, else held.
  - redirect_valid is a one-cycle pulse; latency from EX resolve to redirect is 1 cycle.
- Back-to-back mispredicts produce consecutive pulses with the correct PC for each.
- ex_valid=0: no training, take_branch=0, no redirect; flags still update normally.
- Reset asserted mid-operation: redirect is cancelled immediately and the table returns to CNT_INIT. Table state from before reset is never observable after reset.
- Index arithmetic ignores PC bits above the index range (aliasing is permitted).

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, two extra outputs exist:
  - br_count[31:0]: increments on each clk edge with ex_valid=1.
  - mis_count[31:0]: increments on each edge with mis=1.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=0x0004 -> pred_taken=0, flags=000, redirect_valid=0.
- flag_we=1 with z_in=1; next cycle ex_valid=1, ex_op=001 (BEQ), ex_pred_taken=0, ex_target=0x0040 -> take_branch=1; one cycle later redirect_valid=1 for exactly 1 cycle, redirect_pc=0x0040.
- Same cycle flag_we=1, n_in=1, flags reg N=0, ex_op=011 (BLT) -> take_branch=1 (bypass used).
- Resolve ex_pc=0x0008 taken 3 times with DEPTH=16 -> counter 01→10→11→11; fetch_pc=0x0008 and 0x0018 (alias) both give pred_taken=1. Then 2 not-taken -> pred_taken=0.
- BUNCOND with ex_pred_taken=1 -> take_branch=1, no redirect. BOVFL with V=0, ex_pred_taken=1, ex_fallthru=0x0012 -> redirect_pc=0x0012.
- Drop rst_n while redirect_valid=1 -> redirect_valid=0 immediately; after release all entries predict not-taken. With BRANCH_STATS_EN: 5 branches, 2 mispredicts -> br_count=5, mis_count=2.
